// File: rtl/moto_jogador_param.sv
// Light-cycle player: head cell, direction and turn latch, step timer, grid request/grant
// port for collision reads and cell claims, and a registered RGB overlay for the head cell.
module moto_jogador_param #(
    parameter int GRID_W    = 80,
    parameter int GRID_H    = 60,
    parameter int CELL_BITS = 3,
    parameter int START_X   = 27,
    parameter int START_Y   = 30,
    parameter int START_DIR = 0,
    parameter int PLAYER_ID = 1,
    parameter int TICK_DIV  = 1000000,
    parameter int COLOR_R   = 127,
    parameter int COLOR_G   = 127,
    parameter int COLOR_B   = 0
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       reiniciar,
    input  logic       enable,
    input  logic       btn_ah,
    input  logic       btn_h,
    input  logic [9:0] next_x,
    input  logic [9:0] next_y,
    output logic [7:0] OUT_R,
    output logic [7:0] OUT_G,
    output logic [7:0] OUT_B,
    output logic       mem_req,
    input  logic       mem_gnt,
    output logic       mem_we,
    output logic [5:0] mem_row,
    output logic [6:0] mem_col,
    output logic [1:0] mem_wdata,
    input  logic [1:0] mem_rdata,
    output logic       colidiu,
    output logic [6:0] cab_x,
    output logic [5:0] cab_y
);

    localparam int              TW         = $clog2(TICK_DIV);
    localparam logic [TW-1:0]   TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [7:0]      GRID_W_L   = 8'(GRID_W);
    localparam logic [6:0]      GRID_H_L   = 7'(GRID_H);
    localparam logic [6:0]      START_X_L  = 7'(START_X);
    localparam logic [5:0]      START_Y_L  = 6'(START_Y);
    localparam logic [1:0]      START_D_L  = 2'(START_DIR);
    localparam logic [1:0]      PID_L      = 2'(PLAYER_ID);
    localparam logic [7:0]      COL_R_L    = 8'(COLOR_R);
    localparam logic [7:0]      COL_G_L    = 8'(COLOR_G);
    localparam logic [7:0]      COL_B_L    = 8'(COLOR_B);

    typedef enum logic [2:0] {INIT_WR, WAIT_TICK, RD_REQ, RD_WAIT, WR_REQ, DEAD} state_t;

    logic       rst;
    state_t     state_reg, state_next;
    logic [TW-1:0] tick_reg, tick_next;
    logic [1:0] dir_reg, dir_next, dir_step;
    logic [6:0] head_x_reg, head_x_next;
    logic [5:0] head_y_reg, head_y_next;
    logic [7:0] fut_x_reg, fut_x_next, fut_x_step;
    logic [6:0] fut_y_reg, fut_y_next, fut_y_step;
    logic       turn_pend_reg, turn_pend_next;
    logic       turn_cw_reg, turn_cw_next;
    logic       colidiu_reg, colidiu_next;
    logic       mem_req_reg, mem_req_next;
    logic       mem_we_reg, mem_we_next;
    logic [5:0] mem_row_reg, mem_row_next;
    logic [6:0] mem_col_reg, mem_col_next;
    logic [7:0] out_r_reg, out_g_reg, out_b_reg;
    logic       in_bounds, head_hit;
    logic [1:0] btn_raw, btn_fall;

    assign rst     = reset | reiniciar;
    assign btn_raw = {btn_h, btn_ah};

    // Bit 0 = anti-clockwise, bit 1 = clockwise; buttons idle high, so chains reset to 1.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic s1_reg, s2_reg, s3_reg;
            always_ff @(posedge CLOCK_50) begin
                if (rst) begin
                    s1_reg <= 1'b1;
                    s2_reg <= 1'b1;
                    s3_reg <= 1'b1;
                end else begin
                    s1_reg <= btn_raw[gi];
                    s2_reg <= s1_reg;
                    s3_reg <= s2_reg;
                end
            end
            assign btn_fall[gi] = s3_reg & ~s2_reg;
        end
    endgenerate

    // Direction and target cell as they would be if a step started this cycle.
    always_comb begin
        dir_step = dir_reg;
        if (turn_pend_reg)
            dir_step = turn_cw_reg ? dir_reg + 2'd1 : dir_reg - 2'd1;
        fut_x_step = {1'b0, head_x_reg};
        fut_y_step = {1'b0, head_y_reg};
        case (dir_step)
            2'd0:    fut_x_step = {1'b0, head_x_reg} + 8'd1;
            2'd1:    fut_y_step = {1'b0, head_y_reg} + 7'd1;
            2'd2:    fut_x_step = {1'b0, head_x_reg} - 8'd1;
            default: fut_y_step = {1'b0, head_y_reg} - 7'd1;
        endcase
    end

    // Underflow from 0 wraps to all-ones in the wider field, so one compare covers both edges.
    assign in_bounds = (fut_x_reg < GRID_W_L) && (fut_y_reg < GRID_H_L);

    always_comb begin
        state_next     = state_reg;
        tick_next      = tick_reg;
        dir_next       = dir_reg;
        head_x_next    = head_x_reg;
        head_y_next    = head_y_reg;
        fut_x_next     = fut_x_reg;
        fut_y_next     = fut_y_reg;
        turn_pend_next = turn_pend_reg;
        turn_cw_next   = turn_cw_reg;
        colidiu_next   = colidiu_reg;
        mem_req_next   = mem_req_reg;
        mem_we_next    = mem_we_reg;
        mem_row_next   = mem_row_reg;
        mem_col_next   = mem_col_reg;

        if (!turn_pend_reg && (btn_fall[0] ^ btn_fall[1])) begin
            turn_pend_next = 1'b1;
            turn_cw_next   = btn_fall[1];
        end

        case (state_reg)
            INIT_WR: begin
                if (!mem_req_reg) begin
                    mem_req_next = 1'b1;
                    mem_we_next  = 1'b1;
                    mem_row_next = head_y_reg;
                    mem_col_next = head_x_reg;
                end else if (mem_gnt) begin
                    mem_req_next = 1'b0;
                    state_next   = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (enable) begin
                    if (tick_reg == TICK_LAST) begin
                        tick_next      = '0;
                        dir_next       = dir_step;
                        turn_pend_next = 1'b0;
                        fut_x_next     = fut_x_step;
                        fut_y_next     = fut_y_step;
                        state_next     = RD_REQ;
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
            end
            RD_REQ: begin
                if (!in_bounds) begin
                    colidiu_next = 1'b1;
                    state_next   = DEAD;
                end else if (!mem_req_reg) begin
                    mem_req_next = 1'b1;
                    mem_we_next  = 1'b0;
                    mem_row_next = fut_y_reg[5:0];
                    mem_col_next = fut_x_reg[6:0];
                end else if (mem_gnt) begin
                    mem_req_next = 1'b0;
                    state_next   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_rdata != 2'd0) begin
                    colidiu_next = 1'b1;
                    state_next   = DEAD;
                end else begin
                    state_next = WR_REQ;
                end
            end
            WR_REQ: begin
                if (!mem_req_reg) begin
                    mem_req_next = 1'b1;
                    mem_we_next  = 1'b1;
                    mem_row_next = fut_y_reg[5:0];
                    mem_col_next = fut_x_reg[6:0];
                end else if (mem_gnt) begin
                    mem_req_next = 1'b0;
                    head_x_next  = fut_x_reg[6:0];
                    head_y_next  = fut_y_reg[5:0];
                    state_next   = WAIT_TICK;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_reg     <= INIT_WR;
            tick_reg      <= '0;
            dir_reg       <= START_D_L;
            head_x_reg    <= START_X_L;
            head_y_reg    <= START_Y_L;
            fut_x_reg     <= {1'b0, START_X_L};
            fut_y_reg     <= {1'b0, START_Y_L};
            turn_pend_reg <= 1'b0;
            turn_cw_reg   <= 1'b0;
            colidiu_reg   <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_row_reg   <= '0;
            mem_col_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            tick_reg      <= tick_next;
            dir_reg       <= dir_next;
            head_x_reg    <= head_x_next;
            head_y_reg    <= head_y_next;
            fut_x_reg     <= fut_x_next;
            fut_y_reg     <= fut_y_next;
            turn_pend_reg <= turn_pend_next;
            turn_cw_reg   <= turn_cw_next;
            colidiu_reg   <= colidiu_next;
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            mem_row_reg   <= mem_row_next;
            mem_col_reg   <= mem_col_next;
        end
    end

    assign head_hit = ((next_x >> CELL_BITS) == {3'b000, head_x_reg}) &&
                      ((next_y >> CELL_BITS) == {4'b0000, head_y_reg});

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            out_r_reg <= '0;
            out_g_reg <= '0;
            out_b_reg <= '0;
        end else begin
            out_r_reg <= head_hit ? COL_R_L : 8'd0;
            out_g_reg <= head_hit ? COL_G_L : 8'd0;
            out_b_reg <= head_hit ? COL_B_L : 8'd0;
        end
    end

    assign OUT_R     = out_r_reg;
    assign OUT_G     = out_g_reg;
    assign OUT_B     = out_b_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_row   = mem_row_reg;
    assign mem_col   = mem_col_reg;
    assign mem_wdata = PID_L;
    assign colidiu   = colidiu_reg;
    assign cab_x     = head_x_reg;
    assign cab_y     = head_y_reg;

endmodule

// File: tb/tb_moto_jogador_param.sv
// Directed bench for moto_jogador_param with TICK_DIV=4; grid RAM replaced by driven gnt/rdata.
module tb_moto_jogador_param;

    logic       CLOCK_50 = 1'b0;
    logic       reset, reiniciar, enable, btn_ah, btn_h;
    logic [9:0] next_x, next_y;
    logic [7:0] OUT_R, OUT_G, OUT_B;
    logic       mem_req, mem_gnt, mem_we, colidiu;
    logic [5:0] mem_row, cab_y;
    logic [6:0] mem_col, cab_x;
    logic [1:0] mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    moto_jogador_param #(.TICK_DIV(4)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .reiniciar(reiniciar),
        .enable   (enable),
        .btn_ah   (btn_ah),
        .btn_h    (btn_h),
        .next_x   (next_x),
        .next_y   (next_y),
        .OUT_R    (OUT_R),
        .OUT_G    (OUT_G),
        .OUT_B    (OUT_B),
        .mem_req  (mem_req),
        .mem_gnt  (mem_gnt),
        .mem_we   (mem_we),
        .mem_row  (mem_row),
        .mem_col  (mem_col),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .colidiu  (colidiu),
        .cab_x    (cab_x),
        .cab_y    (cab_y)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Bounded wait for a request of the given kind; a timeout is a failed comparison.
    task automatic wait_req(input logic we, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (mem_req === 1'b1 && mem_we === we) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_req: no request with we=%0b within %0d cycles (mem_req=%b)", we, budget, mem_req);
        end
    endtask

    task automatic wait_head(input int x, input int y, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cab_x == 7'(x) && cab_y == 6'(y)) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_head: head (%0d,%0d) expected (%0d,%0d) within %0d cycles", cab_x, cab_y, x, y, budget);
        end else begin
            $display("head reached (%0d,%0d)", x, y);
        end
    endtask

    task automatic pulse(input bit do_h, input bit do_ah);
        btn_h  = do_h  ? 1'b0 : 1'b1;
        btn_ah = do_ah ? 1'b0 : 1'b1;
        tick(3);
        btn_h  = 1'b1;
        btn_ah = 1'b1;
        tick(3);
    endtask

    task automatic test_reset;
        next_x = 10'd216;
        next_y = 10'd240;
        reset  = 1'b1;
        tick(3);
        checks++;
        if (mem_req !== 1'b0 || colidiu !== 1'b0 || cab_x !== 7'd27 || cab_y !== 6'd30 || OUT_R !== 8'd0) begin
            failures++;
            $display("FAIL reset_state: req=%b col=%b head=(%0d,%0d) R=%0d, expected 0 0 (27,30) 0",
                     mem_req, colidiu, cab_x, cab_y, OUT_R);
        end
        reset = 1'b0;
        tick(1);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_col !== 7'd27 || mem_row !== 6'd30 || mem_wdata !== 2'd1) begin
            failures++;
            $display("FAIL init_write: req=%b we=%b col=%0d row=%0d wd=%0d, expected 1 1 27 30 1",
                     mem_req, mem_we, mem_col, mem_row, mem_wdata);
        end
        checks++;
        if (OUT_R !== 8'd127 || OUT_G !== 8'd127 || OUT_B !== 8'd0) begin
            failures++;
            $display("FAIL overlay_head: RGB=%0d/%0d/%0d, expected 127/127/0", OUT_R, OUT_G, OUT_B);
        end
        tick(1);
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL req_drop: mem_req=%b after grant, expected 0", mem_req);
        end
        $display("reset done, initial write at (27,30)");
    endtask

    task automatic test_step;
        wait_req(1'b0, 20);
        checks++;
        if (mem_col !== 7'd28 || mem_row !== 6'd30) begin
            failures++;
            $display("FAIL step_read_addr: (%0d,%0d), expected (28,30)", mem_col, mem_row);
        end
        wait_head(28, 30, 20);
        checks++;
        if (colidiu !== 1'b0) begin
            failures++;
            $display("FAIL step_colidiu: %b, expected 0", colidiu);
        end
    endtask

    task automatic test_enable_pause;
        int req_seen = 0;
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (mem_req === 1'b1) req_seen++;
        end
        checks++;
        if (req_seen != 0 || cab_x !== 7'd28) begin
            failures++;
            $display("FAIL pause_frozen: req cycles=%0d head_x=%0d, expected 0 and 28", req_seen, cab_x);
        end
        enable = 1'b1;
        tick(4);
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL resume_early: mem_req=%b four cycles after enable, expected 0", mem_req);
        end
        tick(1);
        checks++;
        if (mem_req !== 1'b1 || mem_col !== 7'd29) begin
            failures++;
            $display("FAIL resume_read: req=%b col=%0d, expected 1 and 29", mem_req, mem_col);
        end
        wait_head(29, 30, 20);
    endtask

    task automatic test_turn_single;
        enable = 1'b0;
        pulse(1'b1, 1'b0);
        enable = 1'b1;
        wait_req(1'b0, 20);
        checks++;
        if (mem_col !== 7'd29 || mem_row !== 6'd31) begin
            failures++;
            $display("FAIL turn_cw_read: (%0d,%0d), expected (29,31)", mem_col, mem_row);
        end
        wait_head(29, 31, 20);
    endtask

    task automatic test_two_pulses;
        enable = 1'b0;
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        enable = 1'b1;
        wait_head(28, 31, 20);
    endtask

    task automatic test_simultaneous;
        enable = 1'b0;
        pulse(1'b1, 1'b1);
        enable = 1'b1;
        wait_head(27, 31, 20);
    endtask

    task automatic test_ah_wrap;
        reiniciar = 1'b1;
        tick(1);
        checks++;
        if (cab_x !== 7'd27 || cab_y !== 6'd30 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL reiniciar_state: head=(%0d,%0d) req=%b, expected (27,30) 0", cab_x, cab_y, mem_req);
        end
        reiniciar = 1'b0;
        wait_req(1'b1, 10);
        tick(1);
        enable = 1'b0;
        pulse(1'b0, 1'b1);
        enable = 1'b1;
        wait_head(27, 29, 20);
    endtask

    task automatic test_wall;
        int req_seen = 0;
        bit hit = 1'b0;
        enable = 1'b0;
        pulse(1'b0, 1'b1);
        enable = 1'b1;
        wait_head(0, 29, 400);
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (mem_req === 1'b1) req_seen++;
            if (colidiu === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit || req_seen != 0) begin
            failures++;
            $display("FAIL wall_collide: colidiu=%b req cycles=%0d, expected 1 and 0", colidiu, req_seen);
        end
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (mem_req === 1'b1) req_seen++;
        end
        checks++;
        if (req_seen != 0 || cab_x !== 7'd0 || cab_y !== 6'd29 || colidiu !== 1'b1) begin
            failures++;
            $display("FAIL dead_frozen: req cycles=%0d head=(%0d,%0d) col=%b, expected 0 (0,29) 1",
                     req_seen, cab_x, cab_y, colidiu);
        end
        next_x = 10'd5;
        next_y = 10'd235;
        tick(1);
        checks++;
        if (OUT_R !== 8'd127 || OUT_G !== 8'd127 || OUT_B !== 8'd0) begin
            failures++;
            $display("FAIL overlay_dead: RGB=%0d/%0d/%0d, expected 127/127/0", OUT_R, OUT_G, OUT_B);
        end
        next_x = 10'd8;
        #1;
        checks++;
        if (OUT_R !== 8'd127) begin
            failures++;
            $display("FAIL overlay_latency: R=%0d before clock edge, expected 127", OUT_R);
        end
        tick(1);
        checks++;
        if (OUT_R !== 8'd0 || OUT_G !== 8'd0) begin
            failures++;
            $display("FAIL overlay_off: R=%0d G=%0d, expected 0 0", OUT_R, OUT_G);
        end
        $display("wall collision at (0,29)");
    endtask

    task automatic test_rdata_collision;
        int writes = 0;
        mem_rdata = 2'd2;
        reiniciar = 1'b1;
        tick(1);
        checks++;
        if (colidiu !== 1'b0) begin
            failures++;
            $display("FAIL reiniciar_clear: colidiu=%b, expected 0", colidiu);
        end
        reiniciar = 1'b0;
        wait_req(1'b0, 30);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (mem_req === 1'b1 && mem_we === 1'b1) writes++;
        end
        checks++;
        if (colidiu !== 1'b1 || writes != 0 || cab_x !== 7'd27 || cab_y !== 6'd30) begin
            failures++;
            $display("FAIL occupied_cell: col=%b writes=%0d head=(%0d,%0d), expected 1 0 (27,30)",
                     colidiu, writes, cab_x, cab_y);
        end
        mem_rdata = 2'd0;
        reiniciar = 1'b1;
        tick(1);
        reiniciar = 1'b0;
        checks++;
        if (colidiu !== 1'b0 || cab_x !== 7'd27 || cab_y !== 6'd30) begin
            failures++;
            $display("FAIL restart_after_hit: col=%b head=(%0d,%0d), expected 0 (27,30)", colidiu, cab_x, cab_y);
        end
        $display("occupied-cell collision and restart done");
    endtask

    task automatic test_gnt_delay;
        int unstable = 0;
        wait_req(1'b1, 10);
        tick(1);
        mem_gnt = 1'b0;
        wait_req(1'b0, 20);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_col !== 7'd28 || mem_row !== 6'd30) unstable++;
        end
        checks++;
        if (unstable != 0) begin
            failures++;
            $display("FAIL read_hold: %0d unstable cycles, expected 0 (req=%b we=%b col=%0d row=%0d)",
                     unstable, mem_req, mem_we, mem_col, mem_row);
        end
        mem_gnt = 1'b1;
        tick(1);
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL read_drop: mem_req=%b after delayed grant, expected 0", mem_req);
        end
        mem_gnt = 1'b0;
        wait_req(1'b1, 10);
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_col !== 7'd28 || mem_row !== 6'd30 ||
                mem_wdata !== 2'd1 || cab_x !== 7'd27) unstable++;
        end
        checks++;
        if (unstable != 0) begin
            failures++;
            $display("FAIL write_hold: %0d unstable cycles, expected 0 (req=%b we=%b col=%0d head_x=%0d)",
                     unstable, mem_req, mem_we, mem_col, cab_x);
        end
        mem_gnt = 1'b1;
        wait_head(28, 30, 5);
    endtask

    task automatic test_reset_wins;
        mem_gnt = 1'b0;
        wait_req(1'b0, 20);
        reiniciar = 1'b1;
        tick(1);
        checks++;
        if (mem_req !== 1'b0 || cab_x !== 7'd27 || cab_y !== 6'd30) begin
            failures++;
            $display("FAIL reset_wins: req=%b head=(%0d,%0d), expected 0 (27,30)", mem_req, cab_x, cab_y);
        end
        reiniciar = 1'b0;
        mem_gnt = 1'b1;
        wait_req(1'b1, 5);
        checks++;
        if (mem_col !== 7'd27 || mem_row !== 6'd30) begin
            failures++;
            $display("FAIL restart_write: (%0d,%0d), expected (27,30)", mem_col, mem_row);
        end
        $display("restart over outstanding request done");
    endtask

    initial begin
        reset     = 1'b1;
        reiniciar = 1'b0;
        enable    = 1'b1;
        btn_ah    = 1'b1;
        btn_h     = 1'b1;
        next_x    = 10'd0;
        next_y    = 10'd0;
        mem_gnt   = 1'b1;
        mem_rdata = 2'd0;
        tick(1);
        test_reset;
        test_step;
        test_enable_pause;
        test_turn_single;
        test_two_pulses;
        test_simultaneous;
        test_ah_wrap;
        test_wall;
        test_rdata_collision;
        test_gnt_delay;
        test_reset_wins;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
